mul_appr_booth16: RTL and testbench

//  Pipelined approximate signed multiplier: radix-4 Booth encoding, compressor-tree reduction.
//  The low APPR_COLS product columns use approximate 4:2 compressors to trade accuracy for area/power.

---
 rtl/mul_appr_booth16_pkg.sv | 23 ++
 rtl/mul_appr_booth16_if.sv | 13 +
 rtl/mul_appr_booth16_cmp42_appr.sv | 12 +
 rtl/mul_appr_booth16.sv | 137 +++++++++++++
 tb/tb_mul_appr_booth16.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mul_appr_booth16_pkg.sv
// Shared types and helpers for the approximate radix-4 Booth multiplier.
// Configuration macro: MUL_APPR_EXACT_EN (forces every reduction column to exact cells).
package mul_appr_pkg;

  localparam int WIDTH  = 16;
  localparam int NUM_PP = WIDTH / 2;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  // Window is {b[2i+1], b[2i], b[2i-1]}; the all-ones window is encoded as +0.
  function automatic booth_digit_t booth_enc(input logic [2:0] win);
    booth_digit_t d;
    d.one = win[1] ^ win[0];
    d.two = (win == 3'b011) || (win == 3'b100);
    d.neg = win[2] & ~(win[1] & win[0]);
    return d;
  endfunction

endpackage

// File: rtl/mul_appr_booth16_if.sv
// Operand/product bundle between a datapath and the approximate Booth multiplier.
interface mul_appr_booth16_if #(
  parameter int WIDTH = mul_appr_pkg::WIDTH
);
  logic                      in_valid;
  logic signed [WIDTH-1:0]   a;
  logic signed [WIDTH-1:0]   b;
  logic                      out_valid;
  logic signed [2*WIDTH-1:0] out;

  modport master (output in_valid, a, b, input out_valid, out);
  modport slave  (input in_valid, a, b, output out_valid, out);
endinterface

// File: rtl/mul_appr_booth16_cmp42_appr.sv
// Approximate 4:2 compressor cell: no carry-in/out, undercounts by one when both input pairs are active.
module cmp42_appr (
  input  logic x1_i,
  input  logic x2_i,
  input  logic x3_i,
  input  logic x4_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = (x1_i ^ x2_i) | (x3_i ^ x4_i);
  assign carry_o = (x1_i & x2_i) | (x3_i & x4_i);
endmodule

// File: rtl/mul_appr_booth16.sv
// Two-stage approximate signed multiplier: radix-4 Booth rows, 4:2 row tree, exact CPA.
// Macro MUL_APPR_EXACT_EN overrides APPR_COLS to 0 (bit-exact product). Tree is sized for 8 PP rows.
module mul_appr_booth16
  import mul_appr_pkg::*;
#(
  parameter int WIDTH     = mul_appr_pkg::WIDTH,
  parameter int APPR_COLS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mul_appr_booth16_if.slave   bus
);
  localparam int W   = WIDTH;
  localparam int P   = 2 * WIDTH;
  localparam int NPP = (WIDTH == mul_appr_pkg::WIDTH) ? NUM_PP : WIDTH / 2;
`ifdef MUL_APPR_EXACT_EN
  localparam int APPR_EFF = 0;
`else
  localparam int APPR_EFF = (APPR_COLS < 0) ? 0 : ((APPR_COLS > P) ? P : APPR_COLS);
`endif

  logic [W-1:0] a_q, b_q;
  logic         v1_q, ov_q;
  logic [P-1:0] out_q, prod_d;

  logic [W:0]     pp_bits  [NPP];
  logic [NPP-1:0] neg_bits;
  logic [P-1:0]   rows     [NPP+1];

  for (genvar gi = 0; gi < NPP; gi++) begin : g_pp
    logic [2:0]   win;
    booth_digit_t dig;
    logic [W:0]   mag;
    if (gi == 0) begin : g_w0
      assign win = {b_q[1], b_q[0], 1'b0};
    end else begin : g_wn
      assign win = b_q[2*gi+1 -: 3];
    end
    assign dig          = booth_enc(win);
    assign mag          = dig.two ? {a_q, 1'b0} : (dig.one ? {a_q[W-1], a_q} : '0);
    assign pp_bits[gi]  = mag ^ {(W+1){dig.neg}};
    assign neg_bits[gi] = dig.neg;
  end

  // Constant-ones sign extension; each row's +1 for negation sits in the next row's vacant LSB slot.
  always_comb begin
    for (int r = 0; r <= NPP; r++) rows[r] = '0;
    rows[0][W-1:0] = pp_bits[0][W-1:0];
    rows[0][W]     = pp_bits[0][W];
    rows[0][W+1]   = pp_bits[0][W];
    rows[0][W+2]   = ~pp_bits[0][W];
    for (int i = 1; i < NPP; i++) begin
      rows[i][2*i +: W]  = pp_bits[i][W-1:0];
      rows[i][2*i+W]     = ~pp_bits[i][W];
      rows[i][2*i+W+1]   = 1'b1;
      rows[i][2*i-2]     = neg_bits[i-1];
    end
    rows[NPP][2*NPP-2] = neg_bits[NPP-1];
  end

  // Three 4:2 row compressors: rows 0-3, rows 4-7, then the two resulting pairs.
  logic [P-1:0] cmp_x    [3][4];
  logic [P-1:0] cmp_sum  [3];
  logic [P-1:0] cmp_cry  [3];
  logic [P-1:0] cmp_csh  [3];
  logic [P-1:0] cmp_cout [3];
  logic [P-1:0] cmp_cin  [3];

  for (genvar gj = 0; gj < 4; gj++) begin : g_feed
    assign cmp_x[0][gj] = rows[gj];
    assign cmp_x[1][gj] = rows[gj+4];
  end
  assign cmp_x[2][0] = cmp_sum[0];
  assign cmp_x[2][1] = cmp_csh[0];
  assign cmp_x[2][2] = cmp_sum[1];
  assign cmp_x[2][3] = cmp_csh[1];

  for (genvar gk = 0; gk < 3; gk++) begin : g_cmp
    assign cmp_cin[gk] = {cmp_cout[gk][P-2:0], 1'b0};
    assign cmp_csh[gk] = {cmp_cry[gk][P-2:0], 1'b0};
    for (genvar gc = 0; gc < P; gc++) begin : g_col
      if (gc < APPR_EFF) begin : g_appr
        cmp42_appr u_cell (
          .x1_i   (cmp_x[gk][0][gc]),
          .x2_i   (cmp_x[gk][1][gc]),
          .x3_i   (cmp_x[gk][2][gc]),
          .x4_i   (cmp_x[gk][3][gc]),
          .sum_o  (cmp_sum[gk][gc]),
          .carry_o(cmp_cry[gk][gc])
        );
        assign cmp_cout[gk][gc] = 1'b0;
      end else begin : g_exact
        logic x1, x2, x3, x4, s1, ci;
        assign x1 = cmp_x[gk][0][gc];
        assign x2 = cmp_x[gk][1][gc];
        assign x3 = cmp_x[gk][2][gc];
        assign x4 = cmp_x[gk][3][gc];
        assign ci = cmp_cin[gk][gc];
        assign s1 = x1 ^ x2 ^ x3;
        assign cmp_cout[gk][gc] = (x1 & x2) | (x1 & x3) | (x2 & x3);
        assign cmp_sum[gk][gc]  = s1 ^ x4 ^ ci;
        assign cmp_cry[gk][gc]  = (s1 & x4) | (s1 & ci) | (x4 & ci);
      end
    end
  end

  logic [P-1:0] fa_s, fa_c;
  assign fa_s   = cmp_sum[2] ^ cmp_csh[2] ^ rows[NPP];
  assign fa_c   = (cmp_sum[2] & cmp_csh[2]) | (cmp_sum[2] & rows[NPP]) | (cmp_csh[2] & rows[NPP]);
  assign prod_d = fa_s + {fa_c[P-2:0], 1'b0};

  // Carries out of the top column fall off: the product is modulo 2^P.
  logic unused_msb;
  assign unused_msb = ^{cmp_cin[0], cmp_cin[1], cmp_cin[2],
                        cmp_cout[0][P-1], cmp_cout[1][P-1], cmp_cout[2][P-1],
                        cmp_cry[0][P-1], cmp_cry[1][P-1], cmp_cry[2][P-1], fa_c[P-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      v1_q  <= 1'b0;
      ov_q  <= 1'b0;
      out_q <= '0;
    end else begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      v1_q <= bus.in_valid;
      ov_q <= v1_q;
      if (v1_q) out_q <= prod_d;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.out       = out_q;

endmodule

// File: tb/tb_mul_appr_booth16.sv
// Bench for mul_appr_booth16: an approximate (APPR_COLS=16) and an exact (APPR_COLS=0) instance share stimulus.
module tb_mul_appr_booth16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mul_appr_booth16_if #(.WIDTH(16)) if_ap ();
  mul_appr_booth16_if #(.WIDTH(16)) if_ex ();

  mul_appr_booth16 #(.WIDTH(16), .APPR_COLS(16)) dut_ap (.clk(clk), .rst_n(rst_n), .bus(if_ap));
  mul_appr_booth16 #(.WIDTH(16), .APPR_COLS(0))  dut_ex (.clk(clk), .rst_n(rst_n), .bus(if_ex));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, limit=%0d", 2000000);
    $fatal(1, "watchdog");
  end

  function automatic longint ref_mul(input logic signed [15:0] x, input logic signed [15:0] y);
    return longint'(x) * longint'(y);
  endfunction

  // Drive one operand pair into both instances and advance to 1 time unit past the next rising edge.
  task automatic drive(input logic v, input logic [15:0] av, input logic [15:0] bv);
    if_ap.in_valid = v; if_ap.a = av; if_ap.b = bv;
    if_ex.in_valid = v; if_ex.a = av; if_ex.b = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 16'h1234, 16'h0567);
    drive(1'b1, 16'h4321, 16'h0765);
    checks += 4;
    if (if_ap.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_ap: out_valid=%b expected 0", if_ap.out_valid); end
    if (if_ap.out !== 32'h0)      begin errors++; $display("FAIL reset_out_ap: out=%h expected 00000000", if_ap.out); end
    if (if_ex.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_ex: out_valid=%b expected 0", if_ex.out_valid); end
    if (if_ex.out !== 32'h0)      begin errors++; $display("FAIL reset_out_ex: out=%h expected 00000000", if_ex.out); end
    $display("reset held with in_valid=1: out_valid=%b out=%h", if_ex.out_valid, if_ex.out);

    rst_n = 1'b1;
    drive(1'b1, 16'd100, 16'd7);
    drive(1'b1, -16'sd3, 16'd9);
    checks += 2;
    if (if_ex.out_valid !== 1'b1) begin errors++; $display("FAIL prereset_valid: out_valid=%b expected 1", if_ex.out_valid); end
    if (if_ex.out !== 32'd700)    begin errors++; $display("FAIL prereset_out: out=%h expected %h", if_ex.out, 32'd700); end
    $display("stream before reset: 100*7 -> %h", if_ex.out);

    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (if_ap.out_valid !== 1'b0) begin errors++; $display("FAIL async_valid_ap: out_valid=%b expected 0", if_ap.out_valid); end
    if (if_ap.out !== 32'h0)      begin errors++; $display("FAIL async_out_ap: out=%h expected 00000000", if_ap.out); end
    if (if_ex.out_valid !== 1'b0) begin errors++; $display("FAIL async_valid_ex: out_valid=%b expected 0", if_ex.out_valid); end
    if (if_ex.out !== 32'h0)      begin errors++; $display("FAIL async_out_ex: out=%h expected 00000000", if_ex.out); end
    $display("mid-stream reset: out_valid=%b out=%h", if_ex.out_valid, if_ex.out);

    drive(1'b1, 16'd5, 16'd5);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 16'd11, 16'd13);
      checks += 3;
      if (if_ex.out_valid !== 1'b0) begin errors++; $display("FAIL postreset_valid_ex[%0d]: out_valid=%b expected 0", k, if_ex.out_valid); end
      if (if_ap.out_valid !== 1'b0) begin errors++; $display("FAIL postreset_valid_ap[%0d]: out_valid=%b expected 0", k, if_ap.out_valid); end
      if (if_ex.out !== 32'h0)      begin errors++; $display("FAIL postreset_out_ex[%0d]: out=%h expected 00000000", k, if_ex.out); end
      $display("post-reset cycle %0d: out_valid=%b out=%h", k, if_ex.out_valid, if_ex.out);
    end
  endtask

  task automatic test_exact_vectors();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [31:0] ve [4];
    va[0] = 16'd1000; vb[0] = 16'hFFEF; ve[0] = 32'hFFFFBD98;
    va[1] = 16'h8000; vb[1] = 16'h8000; ve[1] = 32'h40000000;
    va[2] = 16'h7FFF; vb[2] = 16'h7FFF; ve[2] = 32'h3FFF0001;
    va[3] = 16'h8000; vb[3] = 16'h7FFF; ve[3] = 32'hC0008000;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, va[k], vb[k]);
      drive(1'b0, 16'h0, 16'h0);
      checks += 2;
      if (if_ex.out_valid !== 1'b1) begin errors++; $display("FAIL exact_vec_valid[%0d]: out_valid=%b expected 1", k, if_ex.out_valid); end
      if (if_ex.out !== ve[k])      begin errors++; $display("FAIL exact_vec[%0d]: out=%h expected %h", k, if_ex.out, ve[k]); end
      $display("exact a=%h b=%h -> out=%h", va[k], vb[k], if_ex.out);
    end
  endtask

  // With one positive Booth digit and all others zero, low columns hold at most one bit: approximate is exact.
  task automatic test_single_row();
    for (int k = 0; k < 8; k++) begin
      logic [15:0] av;
      logic [15:0] bv;
      logic [31:0] e;
      av = 16'($urandom);
      bv = 16'(1 << (2 * k));
      e  = 32'(ref_mul(av, bv));
      drive(1'b1, av, bv);
      drive(1'b0, 16'h0, 16'h0);
      checks++;
      if (if_ap.out !== e) begin errors++; $display("FAIL single_row[%0d]: out=%h expected %h", k, if_ap.out, e); end
      $display("single row a=%h b=%h -> approx out=%h", av, bv, if_ap.out);
    end
  endtask

  task automatic test_approx_b17();
    int            n = 10000;
    logic [15:0]   pa = 16'h0;
    real           s_e = 0.0, s_e2 = 0.0, s_abs = 0.0;
    for (int i = 0; i <= n; i++) begin
      logic [15:0] av;
      av = 16'($urandom);
      if (i < n) drive(1'b1, av, 16'hFFEF);
      else       drive(1'b0, 16'h0, 16'h0);
      if (i > 0) begin
        longint p, d, e8;
        p  = ref_mul(pa, 16'hFFEF);
        d  = p - longint'($signed(if_ap.out));
        e8 = (longint'($signed(if_ap.out)) >>> 8) - (p >>> 8);
        s_e   += real'(e8);
        s_e2  += real'(e8) * real'(e8);
        s_abs += real'((p >>> 8) < 0 ? -(p >>> 8) : (p >>> 8));
        checks += 3;
        if (if_ap.out_valid !== 1'b1) begin errors++; $display("FAIL b17_valid[%0d]: out_valid=%b expected 1", i, if_ap.out_valid); end
        if (d < 0 || d >= (longint'(1) << 19)) begin
          errors++; $display("FAIL b17_bound[%0d]: a=%h out=%h exact=%0d error=%0d required 0..524287", i, pa, if_ap.out, p, d);
        end
        if (if_ex.out !== 32'(p)) begin errors++; $display("FAIL b17_exact[%0d]: out=%h expected %h", i, if_ex.out, 32'(p)); end
      end
      pa = av;
    end
    begin
      real m, sd, ma;
      m  = s_e / n;
      sd = $sqrt(s_e2 / n - m * m);
      ma = s_abs / n;
      $display("b=-17 approx: mean err=%f std=%f (out>>>8 units); relative mean=%f std=%f", m, sd, m / ma, sd / ma);
    end
  endtask

  task automatic test_random_exact();
    int          n = 10000;
    logic [15:0] pa = 16'h0, pb = 16'h0;
    for (int i = 0; i <= n; i++) begin
      logic [15:0] av, bv;
      av = 16'($urandom);
      bv = 16'($urandom);
      if (i < n) drive(1'b1, av, bv);
      else       drive(1'b0, 16'h0, 16'h0);
      if (i > 0) begin
        longint p, d;
        p = ref_mul(pa, pb);
        d = p - longint'($signed(if_ap.out));
        checks += 2;
        if (if_ex.out !== 32'(p)) begin errors++; $display("FAIL rand_exact[%0d]: a=%h b=%h out=%h expected %h", i, pa, pb, if_ex.out, 32'(p)); end
        if (d < 0 || d >= (longint'(1) << 19)) begin
          errors++; $display("FAIL rand_bound[%0d]: a=%h b=%h out=%h error=%0d required 0..524287", i, pa, pb, if_ap.out, d);
        end
      end
      pa = av;
      pb = bv;
    end
    $display("random a,b: %0d exact products compared", n);
  endtask

  task automatic test_streaming();
    logic        vs [4];
    logic [15:0] as [4];
    logic [15:0] bs [4];
    logic [31:0] held = 32'h0;
    vs[0] = 1'b1; as[0] = 16'd123;  bs[0] = 16'd45;
    vs[1] = 1'b0; as[1] = 16'hFF00; bs[1] = 16'h0F0F;
    vs[2] = 1'b1; as[2] = 16'd77;   bs[2] = 16'hFFF0;
    vs[3] = 1'b1; as[3] = 16'h8001; bs[3] = 16'd3;
    for (int j = 0; j < 6; j++) begin
      if (j < 4) drive(vs[j], as[j], bs[j]);
      else       drive(1'b0, 16'h5555, 16'h3333);
      if (j >= 1) begin
        int   m;
        logic ev;
        m  = j - 1;
        ev = (m < 4) ? vs[m] : 1'b0;
        if (ev) held = 32'(ref_mul(as[m], bs[m]));
        checks += 2;
        if (if_ex.out_valid !== ev) begin errors++; $display("FAIL stream_valid[%0d]: out_valid=%b expected %b", m, if_ex.out_valid, ev); end
        if (if_ex.out !== held)     begin errors++; $display("FAIL stream_out[%0d]: out=%h expected %h", m, if_ex.out, held); end
        $display("stream slot %0d: out_valid=%b out=%h", m, if_ex.out_valid, if_ex.out);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if_ap.in_valid = 1'b0; if_ap.a = '0; if_ap.b = '0;
    if_ex.in_valid = 1'b0; if_ex.a = '0; if_ex.b = '0;
    #1;
    test_reset();
    test_exact_vectors();
    test_single_row();
    test_streaming();
    test_approx_b17();
    test_random_exact();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
